uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the serial transmit path (uart transmitter / hello_world).
- Oversamples `rx` with the system clock at `CLOCKS_PER_BIT` clocks per bit and samples each bit at mid-bit.
- Presents each received byte on a valid/ready holding register.
- Sits between an external serial line and byte-oriented logic, e.g. an echo or loopback check against hello_world.

---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-bit and presents
// received bytes on a valid/ready holding register with framing/overrun flags.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 10,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLOCKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLOCKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is gone by mid-bit is treated as line noise.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
            // Same-cycle consume frees the holding register for the new byte.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; received bytes and flag pulses
// are compared against a queue of bytes the bench itself transmitted.
module tb_uart_rx;

  localparam int unsigned Cpb  = 10;
  localparam int unsigned Sync = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, overrun;

  uart_rx #(
    .CLOCKS_PER_BIT(Cpb),
    .SYNC_STAGES   (Sync)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and flag pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (valid && ready) got_q.push_back(data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && !valid_prev) rise_cyc = cyc;
    end
    valid_prev = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output logic busy_ok);
    busy_ok = 1'b1;
    rx = 1'b0;
    step(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(Cpb / 2);
      if (busy !== 1'b1) busy_ok = 1'b0;
      step(Cpb - Cpb / 2);
    end
    rx = stop;
    step(Cpb);
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] hello[11];
    logic       bok;
    int         fall;
    int         fe0, ov0;
    logic [7:0] rb;

    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    step(1);
    rst = 1'b1;
    step(2 * Cpb);

    // Single byte 'H' with latency bound
    fall = cyc;
    send(8'h48, 1'b1, bok);
    exp_q.push_back(8'h48);
    step(2 * Cpb);
    check("h_busy", bok, 1'b1);
    check("h_latency_ok", ((rise_cyc - fall) <= int'(95 + Sync + 2)), 1'b1);
    check_rx("h");
    check("h_ferr", fe_cnt, 0);

    // "hello world" back-to-back
    for (int i = 0; i < 11; i++) begin
      send(hello[i], 1'b1, bok);
      exp_q.push_back(hello[i]);
    end
    step(2 * Cpb);
    check_rx("hello");
    check("hello_flags", fe_cnt + ov_cnt, 0);

    // Random bytes with random idle gaps
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, 1'b1, bok);
      exp_q.push_back(rb);
      step($urandom_range(0, 2 * Cpb));
    end
    step(2 * Cpb);
    check_rx("rand");

    // 3-clock low glitch on idle line
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(1);
    check("glitch_seen", busy, 1'b1);
    step(Cpb / 2 + Sync + 1 - 4);
    @(negedge clk);
    check("glitch_busy", busy, 1'b0);
    step(2 * Cpb);
    check_rx("glitch");
    check("glitch_flags", fe_cnt + ov_cnt, 0);

    // Framing error then line break, then a good byte
    fe0 = fe_cnt;
    send(8'hA5, 1'b0, bok);
    step(30);
    rx = 1'b1;
    step(Cpb);
    send(8'h3C, 1'b1, bok);
    exp_q.push_back(8'h3C);
    step(2 * Cpb);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check_rx("ferr");
    check("ferr_ovr", ov_cnt, 0);

    // Overrun with consumer stalled
    ready = 1'b0;
    ov0 = ov_cnt;
    send(8'h11, 1'b1, bok);
    send(8'h22, 1'b1, bok);
    step(2 * Cpb);
    @(negedge clk);
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data, 8'h11);
    check("ovr_pulses", ov_cnt - ov0, 1);
    step(1);
    ready = 1'b1;
    exp_q.push_back(8'h11);
    step(2);
    @(negedge clk);
    check("ovr_drain_valid", valid, 1'b0);
    check_rx("ovr");

    // Reset mid-way through bit 4 of 0x55
    rx = 1'b0;
    step(Cpb);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h55 >> i) & 8'h01) != 0;
      step(Cpb);
    end
    rx = 1'b1;
    step(Cpb / 2);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", data, 8'h00);
    check("mrst_valid", valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_flags", {frame_err, overrun}, 2'b00);
    step(2 * Cpb);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send(8'h0F, 1'b1, bok);
    exp_q.push_back(8'h0F);
    step(2 * Cpb);
    check_rx("mrst");
    check("mrst_after_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
